// File: rtl/operand_shifter.sv
// -----------------------------------------------------------------------------
// operand_shifter
//
// Operand serializer for the Montgomery modular multiplier datapath. A WIDTH-bit
// operand is loaded and presented as NDIG = WIDTH/DIGIT digits of DIGIT bits,
// one digit per enabled cycle. The block tracks the number of digits remaining
// and flags the final one, so the MMM controller needs no iteration counter.
//
// Optional feature macro: OPERAND_SHIFTER_MSB_EN
//   defined   : i_msb_first port present, direction latched on load,
//               LSB-first and MSB-first streaming both supported.
//   undefined : LSB-first only, no i_msb_first port.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//   DIGIT  bits emitted per shift (>= 1, divides WIDTH)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clr        synchronous clear (per-operation restart), ignores i_en
//   i_en         cycle enable for load and shift
//   i_ld         load i_a (qualified by i_en)
//   i_a          operand to load
//   i_msb_first  direction select sampled on load (OPERAND_SHIFTER_MSB_EN only)
//   o_digit      current digit
//   o_valid      o_digit holds an unconsumed operand digit
//   o_last       current digit is the final one
//   o_cnt        digits remaining, including the current one
// -----------------------------------------------------------------------------
module operand_shifter #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DIGIT = 1,
  localparam int unsigned NDIG  = WIDTH / DIGIT,
  localparam int unsigned CW    = $clog2(NDIG + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_a,
`ifdef OPERAND_SHIFTER_MSB_EN
  input  logic             i_msb_first,
`endif
  output logic [DIGIT-1:0] o_digit,
  output logic             o_valid,
  output logic             o_last,
  output logic [CW-1:0]    o_cnt
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("operand_shifter: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("operand_shifter: DIGIT must be >= 1 and divide WIDTH");
  end

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             w_dir;       // effective direction: 1 = MSB-first
  logic [WIDTH-1:0] w_sr_shift;  // shift register after consuming one digit

`ifdef OPERAND_SHIFTER_MSB_EN
  logic r_dir;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_dir <= 1'b0;
    end else if (i_en && i_ld) begin
      r_dir <= i_msb_first;
    end
  end

  assign w_dir = r_dir;

  // Both directions zero-fill, so an exhausted stream leaves r_sr all-zero.
  assign w_sr_shift = r_dir ? (r_sr << DIGIT) : (r_sr >> DIGIT);
`else
  assign w_dir      = 1'b0;
  assign w_sr_shift = r_sr >> DIGIT;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_ld) begin
        // A load mid-stream silently restarts the stream.
        r_sr  <= i_a;
        r_cnt <= CW'(NDIG);
      end else if (r_cnt != '0) begin
        r_sr  <= w_sr_shift;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_digit = w_dir ? r_sr[WIDTH-1 -: DIGIT] : r_sr[DIGIT-1:0];
  assign o_valid = (r_cnt != '0);
  assign o_last  = (r_cnt == CW'(1));
  assign o_cnt   = r_cnt;

endmodule
